// File: rtl/mul_rr_arbiter.sv
// rtl/mul_rr_arbiter.sv - round-robin arbitrated shared signed multiplier, 2-stage pipeline
module mul_rr_arbiter #(
  parameter int A     = 8,
  parameter int B     = 8,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int MUL_O = A + B
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*A-1:0] req_a,
  input  logic [N_REQ*B-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ID_W-1:0]    out_id,
  output logic [MUL_O-1:0]   out_data,
  output logic               busy
);

  logic [ID_W-1:0]  ptr;
  logic             s1_valid;
  logic [A-1:0]     s1_a;
  logic [B-1:0]     s1_b;
  logic [ID_W-1:0]  s1_id;

  logic             s2_adv;
  logic             s1_adv;
  logic             cand_found;
  logic [ID_W-1:0]  cand_idx;
  logic             handshake;
  logic [MUL_O-1:0] product;

  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign handshake = cand_found && s1_adv && i_resetn;
  assign busy      = s1_valid | out_valid;

  // Full-width signed product; operands are sign-extended so nothing is truncated.
  assign product = $signed({{(MUL_O-A){s1_a[A-1]}}, s1_a}) *
                   $signed({{(MUL_O-B){s1_b[B-1]}}, s1_b});

  // Round-robin scan: first valid lane at or after ptr, wrapping past N_REQ-1.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!cand_found && req_valid[ID_W'(j)]) begin
        cand_found = 1'b1;
        cand_idx   = ID_W'(j);
      end
    end
  end

  // Grant only the candidate, only when stage 1 can take it; held low in reset.
  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[cand_idx] = 1'b1;
  end

  // Pipeline and pointer state; reset discards both stages immediately.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      ptr       <= '0;
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= handshake;
        if (handshake) begin
          s1_a  <= req_a[int'(cand_idx)*A +: A];
          s1_b  <= req_b[int'(cand_idx)*B +: B];
          s1_id <= cand_idx;
          ptr   <= (int'(cand_idx) == N_REQ - 1) ? '0 : cand_idx + ID_W'(1);
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= product;
          out_id   <= s1_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// tb/tb_mul_rr_arbiter.sv - self-checking bench for mul_rr_arbiter
module tb_mul_rr_arbiter;

  logic        i_clk = 1'b0;
  logic        i_resetn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_id;
  logic [15:0] out_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mul_rr_arbiter dut (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: in-flight results in acceptance order, each aged in edges.
  typedef struct {
    int          id;
    logic [15:0] prod;
    int          age;
  } item_t;

  item_t q[$];
  int    mptr = 0;

  always @(negedge i_clk) begin
    if (!i_resetn) begin
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_id", 32'(out_id), 32'h0);
      q.delete();
      mptr = 0;
    end else begin
      int         g;
      bit         room;
      bit         exp_ov;
      logic [3:0] exp_ready;
      room = (q.size() < 2) || out_ready;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (mptr + k) % 4;
        if (g < 0 && req_valid[2'(j)]) g = j;
      end
      exp_ready = (g >= 0 && room) ? (4'b0001 << g) : 4'b0000;
      exp_ov = (q.size() > 0) && (q[0].age >= 2);
      chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
      chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
      chk("m_busy", 32'(busy), 32'(q.size() > 0));
      if (exp_ov) begin
        chk("m_out_data", 32'(out_data), 32'(q[0].prod));
        chk("m_out_id", 32'(out_id), 32'(q[0].id));
      end
      if (exp_ov && out_ready) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (exp_ready != 4'b0000) begin
        item_t it;
        int    av;
        int    bv;
        av = int'($signed(req_a[g*8 +: 8]));
        bv = int'($signed(req_b[g*8 +: 8]));
        it.id = g;
        it.prod = 16'(av * bv);
        it.age = 1;
        q.push_back(it);
        mptr = (g + 1) % 4;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input int a, input int b);
    req_valid[lane] = 1'b1;
    req_a[lane*8 +: 8] = 8'(a);
    req_b[lane*8 +: 8] = 8'(b);
  endtask

  // One isolated request with out_ready high: grant now, result two cycles later.
  task automatic single(input int lane, input int a, input int b, input logic [15:0] exp_data);
    set_lane(lane, a, b);
    #1;
    chk("single_grant", 32'(req_ready), 32'(4'b0001 << lane));
    step();
    req_valid = '0;
    #1;
    chk("single_not_yet", 32'(out_valid), 32'h0);
    step();
    #1;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'(exp_data));
    chk("single_id", 32'(out_id), 32'(lane));
  endtask

  initial begin
    // Reset: requests present but nothing may be granted
    req_valid = 4'b1111;
    step();
    step();
    #1;
    chk("lit_rst_ready", 32'(req_ready), 32'h0);
    chk("lit_rst_busy", 32'(busy), 32'h0);
    req_valid = '0;
    i_resetn = 1'b1;
    step();

    // Round-robin with all lanes requesting continuously
    for (int i = 0; i < 4; i++) set_lane(i, i + 1, 10);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        chk("rr_out_valid", 32'(out_valid), 32'h1);
        chk("rr_out_id", 32'(out_id), 32'((k - 2) % 4));
      end
      step();
    end
    req_valid = '0;
    step();
    step();
    step();

    // Basic multiplies and extremes
    single(0, 48, 20, 16'd960);
    single(2, -4, 2, 16'hFFF8);
    single(3, -128, -128, 16'h4000);
    single(0, 127, -128, 16'hC080);
    single(1, 0, -1, 16'h0000);
    step();

    // Pointer hold: lane1 accepted leaves ptr=2, so lane0 wins over lane1
    single(1, 3, 4, 16'd12);
    set_lane(0, 5, 6);
    set_lane(1, 7, 8);
    #1;
    chk("ptr_wrap_lane0", 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("ptr_then_lane1", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    step();
    step();

    // Backpressure: two in flight, third held off until out_ready returns
    out_ready = 1'b0;
    set_lane(0, 2, 3);
    #1;
    chk("bp_grant1", 32'(req_ready), 32'h1);
    step();
    set_lane(0, 4, 5);
    #1;
    chk("bp_grant2", 32'(req_ready), 32'h1);
    step();
    set_lane(0, 6, 7);
    #1;
    chk("bp_block", 32'(req_ready), 32'h0);
    chk("bp_hold_data", 32'(out_data), 32'd6);
    step();
    #1;
    chk("bp_still_block", 32'(req_ready), 32'h0);
    chk("bp_still_data", 32'(out_data), 32'd6);
    chk("bp_busy", 32'(busy), 32'h1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    #1;
    chk("bp_second", 32'(out_data), 32'd20);
    step();
    #1;
    chk("bp_third", 32'(out_data), 32'd42);
    step();
    #1;
    chk("bp_drained", 32'(busy), 32'h0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    set_lane(1, 3, 3);
    step();
    step();
    req_valid = 4'b1111;
    #1;
    chk("ar_full_busy", 32'(busy), 32'h1);
    chk("ar_full_valid", 32'(out_valid), 32'h1);
    #1;
    i_resetn = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'h0);
    chk("ar_req_ready", 32'(req_ready), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    step();
    step();
    i_resetn = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    set_lane(0, 5, 5);
    set_lane(3, -1, 7);
    #1;
    chk("ar_ptr_reset", 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("ar_lane3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    #1;
    chk("ar_lane0_result", 32'(out_data), 32'd25);
    step();
    #1;
    chk("ar_lane3_result", 32'(out_data), 32'hFFF9);
    chk("ar_lane3_id", 32'(out_id), 32'd3);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
